// File: rtl/road_merge_arbiter.sv
// Four-plane road merger: one FIFO per plane, round-robin drain into a registered
// valid/ready output tagged with the source plane, plus an end-of-run drain sequence.
module road_fifo #(
  parameter int DATA_W  = 30,
  parameter int FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              drop
);
  localparam int DEPTH = 2**FIFO_AW;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   cnt;
  logic               full, wr;

  assign full  = (cnt == (FIFO_AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  // a full FIFO still takes the word when it is being popped this cycle
  assign wr    = push && (!full || pop);
  assign drop  = push && !wr;
  assign dout  = mem[rp];

  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module road_merge_arbiter #(
  parameter int DATA_W  = 30,
  parameter int FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] p0_road_data,
  input  logic [DATA_W-1:0] p1_road_data,
  input  logic [DATA_W-1:0] p2_road_data,
  input  logic [DATA_W-1:0] p3_road_data,
  input  logic              p0_road_dv,
  input  logic              p1_road_dv,
  input  logic              p2_road_dv,
  input  logic              p3_road_dv,
  input  logic              eor,
  output logic [DATA_W+1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              eor_done,
  output logic              busy,
  output logic [3:0]        ovf,
  output logic [15:0]       drop_cnt
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  logic [NUM_LANES-1:0]             dv, empty, drop, pop;
  logic [NUM_LANES-1:0][DATA_W-1:0] din, dout;
  logic [1:0]  last_grant, gnt, idx;
  logic        gnt_vld, load, drain_ok, eor_q;
  logic [2:0]  drop_sum;
  logic [16:0] drop_nxt;
  state_t      state;

  assign dv  = {p3_road_dv, p2_road_dv, p1_road_dv, p0_road_dv};
  assign din = {p3_road_data, p2_road_data, p1_road_data, p0_road_data};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    road_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (dv[i]),
      .din  (din[i]),
      .pop  (pop[i]),
      .dout (dout[i]),
      .empty(empty[i]),
      .drop (drop[i])
    );
  end

  // search starts just after the last winner, so the winner ends up lowest priority
  always_comb begin
    gnt     = last_grant;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = last_grant + 2'(k);
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign load = !out_valid || out_ready;
  assign pop  = (load && gnt_vld) ? (NUM_LANES'(1) << gnt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      last_grant <= 2'd3;
    end else if (load) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data   <= {gnt, dout[gnt]};
        last_grant <= gnt;
      end
    end
  end

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) drop_sum = drop_sum + 3'(drop[i]);
  end
  assign drop_nxt = {1'b0, drop_cnt} + 17'(drop_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= '0;
      drop_cnt <= '0;
    end else begin
      ovf      <= ovf | drop;
      drop_cnt <= drop_nxt[16] ? 16'hFFFF : drop_nxt[15:0];
    end
  end

  // nothing buffered, nothing left in the output register, nothing arriving
  assign drain_ok = (&empty) && (!out_valid || out_ready) && !(|dv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      eor_q    <= 1'b0;
      busy     <= 1'b0;
      eor_done <= 1'b0;
    end else begin
      eor_q    <= eor;
      eor_done <= 1'b0;
      case (state)
        RUN: if (eor && !eor_q) begin
          state <= DRAIN;
          busy  <= 1'b1;
        end
        DRAIN: if (drain_ok) begin
          state    <= DONE;
          eor_done <= 1'b1;
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_road_merge_arbiter.sv
// Bench for road_merge_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_road_merge_arbiter;
  localparam int DATA_W = 30;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] pdata [4];
  logic [3:0]        pdv;
  logic              eor, out_ready;
  logic [DATA_W+1:0] out_data;
  logic              out_valid, eor_done, busy;
  logic [3:0]        ovf;
  logic [15:0]       drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  road_merge_arbiter #(.DATA_W(DATA_W), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst),
    .p0_road_data(pdata[0]), .p1_road_data(pdata[1]),
    .p2_road_data(pdata[2]), .p3_road_data(pdata[3]),
    .p0_road_dv(pdv[0]), .p1_road_dv(pdv[1]),
    .p2_road_dv(pdv[2]), .p3_road_dv(pdv[3]),
    .eor(eor), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .eor_done(eor_done), .busy(busy), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef logic [DATA_W-1:0] wq_t [$];
  wq_t               mq [4];
  logic              m_valid = 1'b0;
  logic [DATA_W+1:0] m_data  = '0;
  int                m_lg    = 3;
  int                m_state = 0;   // 0 run, 1 drain, 2 done
  logic              m_eor_q = 1'b0;
  logic              m_done  = 1'b0;
  logic              m_busy  = 1'b0;
  logic [3:0]        m_ovf   = '0;
  logic [15:0]       m_drop  = '0;

  task automatic model_reset();
    for (int p = 0; p < 4; p++) mq[p].delete();
    m_valid = 1'b0; m_data = '0; m_lg = 3; m_state = 0; m_eor_q = 1'b0;
    m_done = 1'b0; m_busy = 1'b0; m_ovf = '0; m_drop = '0;
  endtask

  task automatic model_step();
    bit all_empty, drain_ok, found;
    int g;
    all_empty = 1'b1;
    for (int p = 0; p < 4; p++) if (mq[p].size() != 0) all_empty = 1'b0;
    drain_ok = all_empty && (!m_valid || out_ready) && (pdv == 4'b0);
    if (!m_valid || out_ready) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        g = (m_lg + k) % 4;
        if (!found && mq[g].size() > 0) begin
          found  = 1'b1;
          m_data = {2'(g), mq[g].pop_front()};
          m_lg   = g;
        end
      end
      m_valid = found;
    end
    for (int p = 0; p < 4; p++) begin
      if (pdv[p]) begin
        if (mq[p].size() < 8) mq[p].push_back(pdata[p]);
        else begin
          m_ovf[p] = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
    end
    case (m_state)
      0:       if (eor && !m_eor_q) m_state = 1;
      1:       if (drain_ok) m_state = 2;
      default: m_state = 0;
    endcase
    m_done  = (m_state == 2);
    m_busy  = (m_state != 0);
    m_eor_q = eor;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("m_out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) chk("m_out_data", 64'(out_data), 64'(m_data));
    chk("m_eor_done", 64'(eor_done), 64'(m_done));
    chk("m_busy", 64'(busy), 64'(m_busy));
    chk("m_ovf", 64'(ovf), 64'(m_ovf));
    chk("m_drop_cnt", 64'(drop_cnt), 64'(m_drop));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; pdv = '0; eor = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int hs, last_hs, done_cyc;
    bit done_seen;
    pdv = '0; eor = 1'b0; out_ready = 1'b0;
    for (int p = 0; p < 4; p++) pdata[p] = '0;
    idle(2);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_eor_done", 64'(eor_done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // single word latency
    out_ready = 1'b1;
    pdv[2] = 1'b1; pdata[2] = 30'h0ABCDEF;
    tick(); pdv = '0;
    chk("sw_c1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("sw_c2_valid", 64'(out_valid), 64'd1);
    chk("sw_c2_data", 64'(out_data), 64'({2'd2, 30'h0ABCDEF}));
    tick();
    chk("sw_c3_valid", 64'(out_valid), 64'd0);

    // round robin over backlogged ports
    do_reset();
    out_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int p = 0; p < 4; p++) begin
        pdv[p] = 1'b1; pdata[p] = 30'(p * 16 + w);
      end
      tick();
    end
    pdv = '0;
    idle(2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_port", 64'(out_data[DATA_W+1:DATA_W]), 64'(i % 4));
      chk("rr_data", 64'(out_data), 64'({2'(i % 4), 30'((i % 4) * 16 + i / 4)}));
      tick();
    end
    chk("rr_empty", 64'(out_valid), 64'd0);

    // backpressure holds the output register
    out_ready = 1'b0;
    pdv[3] = 1'b1; pdata[3] = 30'h3A5;
    tick();
    pdv = '0; pdv[0] = 1'b1; pdata[0] = 30'h0C3;
    tick();
    pdv = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'(out_data), 64'({2'd3, 30'h3A5}));
      tick();
    end
    out_ready = 1'b1;
    chk("bp_release", 64'(out_data), 64'({2'd3, 30'h3A5}));
    tick();
    chk("bp_next", 64'(out_data), 64'({2'd0, 30'h0C3}));
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // overflow on port 1 with the output register occupied
    out_ready = 1'b0;
    pdv[0] = 1'b1; pdata[0] = 30'h111;
    tick(); pdv = '0;
    idle(2);
    for (int i = 0; i < 10; i++) begin
      pdv[1] = 1'b1; pdata[1] = 30'(32'h100 + i);
      tick();
    end
    pdv = '0;
    tick();
    chk("ovf_flags", 64'(ovf), 64'h2);
    chk("ovf_drops", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    chk("ovf_head", 64'(out_data), 64'({2'd0, 30'h111}));
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", 64'(out_data), 64'({2'd1, 30'(32'h100 + i)}));
      tick();
    end
    chk("ovf_empty", 64'(out_valid), 64'd0);
    idle(3);
    chk("ovf_sticky", 64'(ovf), 64'h2);

    // eor held high on an empty block: one pulse, no retrigger
    eor = 1'b1;
    tick();
    chk("eorl_c1_busy", 64'(busy), 64'd1);
    chk("eorl_c1_done", 64'(eor_done), 64'd0);
    tick();
    chk("eorl_c2_done", 64'(eor_done), 64'd1);
    chk("eorl_c2_busy", 64'(busy), 64'd1);
    tick();
    chk("eorl_c3_done", 64'(eor_done), 64'd0);
    chk("eorl_c3_busy", 64'(busy), 64'd0);
    idle(2);
    chk("eorl_noretrig", 64'(busy), 64'd0);
    eor = 1'b0;
    tick();

    // drain with a word arriving during DRAIN
    out_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pdv[p] = 1'b1; pdata[p] = 30'(32'h200 + p);
    end
    tick(); pdv = '0;
    eor = 1'b1;
    tick(); eor = 1'b0;
    chk("dr_busy_start", 64'(busy), 64'd1);
    out_ready = 1'b1;
    pdv[3] = 1'b1; pdata[3] = 30'h2FF;
    hs = 0; last_hs = -1; done_seen = 1'b0; done_cyc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 1) pdv = '0;
      if (eor_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        break;
      end
      chk("dr_busy", 64'(busy), 64'd1);
      if (out_valid && out_ready) begin
        hs++;
        last_hs = cyc;
      end
      tick();
    end
    if (!done_seen) begin
      n_checks++; n_fail++;
      $display("FAIL dr_timeout: eor_done not seen within 40 cycles");
    end else begin
      chk("dr_count", 64'(hs), 64'd4);
      chk("dr_latency", 64'(done_cyc), 64'(last_hs + 1));
      chk("dr_busy_done", 64'(busy), 64'd1);
      tick();
      chk("dr_pulse_end", 64'(eor_done), 64'd0);
      chk("dr_busy_end", 64'(busy), 64'd0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 4; p++) begin
        pdv[p]   = ($urandom_range(99) < 25);
        pdata[p] = 30'($urandom);
      end
      out_ready = ($urandom_range(99) < 70);
      eor       = ($urandom_range(99) < 3);
      tick();
    end
    pdv = '0; eor = 1'b0; out_ready = 1'b1;
    idle(50);

    // reset in the middle of a drain
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      pdv[p] = 1'b1; pdata[p] = 30'(32'h300 + p);
    end
    tick(); pdv = '0;
    eor = 1'b1;
    tick(); eor = 1'b0;
    tick();
    chk("rmd_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmd_valid", 64'(out_valid), 64'd0);
    chk("rmd_busy0", 64'(busy), 64'd0);
    chk("rmd_done0", 64'(eor_done), 64'd0);
    chk("rmd_ovf0", 64'(ovf), 64'd0);
    chk("rmd_drop0", 64'(drop_cnt), 64'd0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("rmd_no_stale", 64'(out_valid), 64'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
